// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RISC-V funct3 size
// codes, lane helpers and request legality checks.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  // Bit position of the least significant bit of byte lane 'lo' in a word.
  function automatic logic [4:0] byte_lsb(input logic [1:0] lo);
    return {lo, 3'b000};
  endfunction

  // Unsigned size codes only make sense for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem_master_if.sv
// CPU request/response channel plus the word-addressed DMEM port, as seen by
// the load/store unit (master) and by its environment (slave).
interface lsu_dmem_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic              mem_MemRW;
  logic [31:0]       mem_read_data;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  rsp_ready, mem_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_address, mem_write_data, mem_MemRW
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output rsp_ready, mem_read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_address, mem_write_data, mem_MemRW
  );
endinterface

// File: rtl/lsu_align.sv
// Lane steering: formats a loaded word into an extended result and merges
// sub-word store data into a word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    load_data  = word;
    store_word = wdata;
    byte_sel   = word[byte_lsb(addr_lo) +: BYTE_W];
    half_sel   = addr_lo[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:  load_data = {{(32-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      F3_BU: load_data = {{(32-BYTE_W){1'b0}}, byte_sel};
      F3_H:  load_data = {{(32-HALF_W){half_sel[HALF_W-1]}}, half_sel};
      F3_HU: load_data = {{(32-HALF_W){1'b0}}, half_sel};
      default: ;
    endcase

    case (funct3)
      F3_B: begin
        store_word = word;
        store_word[byte_lsb(addr_lo) +: BYTE_W] = wdata[BYTE_W-1:0];
      end
      F3_H: begin
        store_word = word;
        if (addr_lo[1]) store_word[31:16] = wdata[HALF_W-1:0];
        else            store_word[15:0]  = wdata[HALF_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store unit driving a word-addressed DMEM without byte enables; byte and
// halfword stores are performed as read-modify-write.
module lsu_dmem_master
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 32
) (
  input logic               clk,
  input logic               rst,
  lsu_dmem_master_if.master bus
);

  lsu_state_e        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic              req_err;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       align_word;
  logic [31:0]       load_data;
  logic [31:0]       store_word;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic              mem_we;

  assign accept    = bus.req_valid && (state == ST_IDLE);
  assign req_err   = f3_misaligned(bus.req_funct3, bus.req_addr[1:0])
                  || (bus.req_addr >= ADDR_W'(MEM_BYTES))
                  || !f3_legal(bus.req_funct3, bus.req_we);
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // The RMW write merges into the word captured during RMW_RD, not the live bus.
  assign align_word = (state == ST_RMW_WR) ? word_q : bus.mem_read_data;

  lsu_align u_align (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .word       (align_word),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_nxt      = state;
    mem_address    = '0;
    mem_write_data = '0;
    mem_we         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                                    state_nxt = ST_RESP;
          else if (!bus.req_we || bus.req_funct3 == F3_W) state_nxt = ST_ACCESS;
          else                                            state_nxt = ST_RMW_RD;
        end
      end
      ST_ACCESS: begin
        mem_address = word_addr;
        if (we_q) begin
          mem_we         = 1'b1;
          mem_write_data = wdata_q;
        end
        state_nxt = ST_RESP;
      end
      ST_RMW_RD: begin
        mem_address = word_addr;
        state_nxt   = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        mem_address    = word_addr;
        mem_we         = 1'b1;
        mem_write_data = store_word;
        state_nxt      = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Response fields are cleared at accept so stores and errors return zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here update from
      // the pre-edge values, independent of statement order.
      state <= state_nxt;
      if (accept) begin
        addr_q  <= bus.req_addr;
        f3_q    <= bus.req_funct3;
        we_q    <= bus.req_we;
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (state == ST_ACCESS && !we_q) rdata_q <= load_data;
      if (state == ST_RMW_RD)          word_q  <= bus.mem_read_data;
    end
  end

  // Write strobe is decoded from state, so an asynchronous reset drops it at once.
  assign bus.req_ready      = (state == ST_IDLE);
  assign bus.rsp_valid      = (state == ST_RESP);
  assign bus.rsp_rdata      = rdata_q;
  assign bus.rsp_err        = err_q;
  assign bus.mem_address    = mem_address;
  assign bus.mem_write_data = mem_write_data;
  assign bus.mem_MemRW      = mem_we;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master against a small combinational-read DMEM.
module tb_lsu_dmem_master;
  import lsu_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_dmem_master_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_dmem_master #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;
  int          wr_count = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  assign bus.mem_read_data = mem[bus.mem_address[11:2]];

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (bus.mem_MemRW && !rst) begin
      mem[bus.mem_address[11:2]] <= bus.mem_write_data;
      wr_count <= wr_count + 1;
      wr_addr  <= bus.mem_address;
      wr_data  <= bus.mem_write_data;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Presents one request; lat = edges from the accept edge (inclusive) to rsp_valid.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat);
    @(negedge clk);
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_txn(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int lat;
    run_req(we, f3, addr, wdata, lat);
    check({tag, "_lat"},   lat,           exp_lat);
    check({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
    check({tag, "_err"},   bus.rsp_err,   exp_err);
    ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0;
    int lat;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    poke(10'd4, 32'h8899AABB);
    poke(10'd8, 32'h00000000);

    @(negedge clk);
    check("rst_req_ready", bus.req_ready,      1);
    check("rst_rsp_valid", bus.rsp_valid,      0);
    check("rst_rsp_rdata", bus.rsp_rdata,      0);
    check("rst_rsp_err",   bus.rsp_err,        0);
    check("rst_memrw",     bus.mem_MemRW,      0);
    check("rst_mem_addr",  bus.mem_address,    0);
    check("rst_mem_wdata", bus.mem_write_data, 0);
    rst = 1'b0;

    do_txn("lb_11",  0, F3_B,  32'h11, 0, 32'hFFFFFFAA, 0, 2);
    do_txn("lbu_11", 0, F3_BU, 32'h11, 0, 32'h000000AA, 0, 2);
    do_txn("lhu_12", 0, F3_HU, 32'h12, 0, 32'h00008899, 0, 2);
    do_txn("lh_12",  0, F3_H,  32'h12, 0, 32'hFFFF8899, 0, 2);

    w0 = wr_count;
    do_txn("sw_20", 1, F3_W, 32'h20, 32'hDEADBEEF, 0, 0, 2);
    check("sw_writes", wr_count - w0, 1);
    check("sw_waddr",  wr_addr,       32'h20);
    check("sw_wdata",  wr_data,       32'hDEADBEEF);
    do_txn("lw_20", 0, F3_W, 32'h20, 0, 32'hDEADBEEF, 0, 2);

    w0 = wr_count;
    do_txn("sb_12", 1, F3_B, 32'h12, 32'h0000005C, 0, 0, 3);
    check("sb_writes", wr_count - w0, 1);
    check("sb_waddr",  wr_addr,       32'h10);
    check("sb_wdata",  wr_data,       32'h885CAABB);
    check("sb_mem",    mem[4],        32'h885CAABB);

    do_txn("sh_22", 1, F3_H, 32'h22, 32'hFFFF1234, 0, 0, 3);
    check("sh_mem", mem[8], 32'h1234BEEF);

    poke(10'd4, 32'h8899AABB);
    w0 = wr_count;
    do_txn("sh_mis", 1, F3_H, 32'h11, 32'h00001234, 0, 1, 1);
    check("sh_mis_writes", wr_count - w0, 0);
    check("sh_mis_mem",    mem[4],        32'h8899AABB);

    do_txn("lw_oor",   0, F3_W,   32'h1000, 0, 0, 1, 1);
    do_txn("f3_011",   0, 3'b011, 32'h10,   0, 0, 1, 1);
    do_txn("st_bu",    1, F3_BU,  32'h10,   0, 0, 1, 1);
    check("err_writes", wr_count - w0, 0);

    // Reset while the SB is in its read phase.
    w0 = wr_count;
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_funct3 = F3_B; bus.req_addr = 32'h12;
    bus.req_wdata = 32'h5C; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rmw_rd_addr", bus.mem_address, 32'h10);
    rst = 1'b1;
    #1;
    check("mid_rst_memrw", bus.mem_MemRW, 0);
    check("mid_rst_ready", bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", bus.rsp_valid, 0);
    end
    check("post_rst_ready",  bus.req_ready,  1);
    check("post_rst_writes", wr_count - w0,  0);
    check("post_rst_mem",    mem[4],         32'h8899AABB);

    // Back-pressure on the response channel.
    run_req(0, F3_BU, 32'h11, 0, lat);
    check("hold_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_rdata", bus.rsp_rdata, 32'h000000AA);
      check("hold_ready", bus.req_ready, 0);
    end
    ack();
    check("after_ack_valid", bus.rsp_valid, 0);
    check("after_ack_ready", bus.req_ready, 1);
    do_txn("next_lb", 0, F3_B, 32'h13, 0, 32'hFFFFFF88, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
